// File: rtl/oled_spi_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : oled_spi_rx_if
// Description : Bundles the OLED SPI pins (csn, clk, mosi, dc, resn) and the
//               decoded pixel / command outputs of oled_spi_rx.
//               master : drives the SPI pins, consumes decoded writes
//               slave  : the receiver (samples pins, produces writes)
// Revision    : 1.0 - initial release
// ============================================================================
interface oled_spi_rx_if;
    logic       oled_csn;
    logic       oled_clk;
    logic       oled_mosi;
    logic       oled_dc;
    logic       oled_resn;
    logic       pix_valid;
    logic [7:0] pix_x;
    logic [5:0] pix_y;
    logic [7:0] pix_color;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       frame_done;

    modport master (
        output oled_csn, oled_clk, oled_mosi, oled_dc, oled_resn,
        input  pix_valid, pix_x, pix_y, pix_color, cmd_valid, cmd_byte, frame_done
    );

    modport slave (
        input  oled_csn, oled_clk, oled_mosi, oled_dc, oled_resn,
        output pix_valid, pix_x, pix_y, pix_color, cmd_valid, cmd_byte, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/oled_spi_rx.sv
`default_nettype none
// ============================================================================
// Module      : oled_spi_rx
// Description : Oversampling SPI receiver for an SSD1331-style OLED stream.
//               Frames bytes, decodes column/row window commands and emits
//               one (x, y, color) write per pixel byte.
// Ports       : clk    - system clock (>= 4x SPI clock)
//               reset  - synchronous, active-high
//               bus    - oled_spi_rx_if.slave: SPI pins in; pix_*, cmd_*,
//                        frame_done out (all outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module oled_spi_rx #(
    parameter int SCREEN_WIDTH  = 96,
    parameter int SCREEN_HEIGHT = 64,
    parameter int SYNC_STAGES   = 2
) (
    input  wire logic     clk,
    input  wire logic     reset,
    oled_spi_rx_if.slave  bus
);

    // Pin vector bit positions
    localparam int c_csn  = 0;
    localparam int c_sclk = 1;
    localparam int c_mosi = 2;
    localparam int c_dc   = 3;
    localparam int c_resn = 4;

    // Idle pin levels: deselected, clock low, display out of reset
    localparam logic [4:0] c_pins_idle = 5'b1_0001;

    localparam logic [6:0] c_col_max = 7'(SCREEN_WIDTH - 1);
    localparam logic [5:0] c_row_max = 6'(SCREEN_HEIGHT - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_col_s = 3'd1;
    localparam logic [2:0] c_st_col_e = 3'd2;
    localparam logic [2:0] c_st_row_s = 3'd3;
    localparam logic [2:0] c_st_row_e = 3'd4;

    logic [4:0]                  w_pins;
    logic [SYNC_STAGES-1:0][4:0] r_sync;
    logic [4:0]                  r_prev;
    logic [4:0]                  w_cur;

    assign w_pins = {bus.oled_resn, bus.oled_dc, bus.oled_mosi, bus.oled_clk, bus.oled_csn};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync[0] <= c_pins_idle;
            r_prev    <= c_pins_idle;
        end else begin
            r_sync[0] <= w_pins;
            r_prev    <= w_cur;
        end
    end

    for (genvar i = 1; i < SYNC_STAGES; i++) begin : g_sync
        always_ff @(posedge clk) begin
            if (reset) r_sync[i] <= c_pins_idle;
            else       r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_cur = r_sync[SYNC_STAGES-1];

    logic       w_rise;
    logic       w_shift;
    logic       w_byte_done;
    logic [7:0] w_byte;
    logic       w_clr;
    logic [6:0] w_col_end;
    logic [5:0] w_row_end;

    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [2:0] r_state;
    logic [6:0] r_start_tmp;
    logic [6:0] r_col_start;
    logic [6:0] r_col_end;
    logic [5:0] r_row_start;
    logic [5:0] r_row_end;
    logic [6:0] r_x;
    logic [5:0] r_y;

    logic       r_pix_valid;
    logic [7:0] r_pix_x;
    logic [5:0] r_pix_y;
    logic [7:0] r_pix_color;
    logic       r_cmd_valid;
    logic [7:0] r_cmd_byte;
    logic       r_frame_done;

    assign w_rise = w_cur[c_sclk] & ~r_prev[c_sclk];
    // csn is taken as active if it was low on either of the two samples, so a
    // csn rise landing together with the final clock edge still completes the byte.
    assign w_shift     = w_rise & (~w_cur[c_csn] | ~r_prev[c_csn]);
    assign w_byte_done = w_shift & (r_bit_cnt == 3'd7);
    assign w_byte      = {r_shift[6:0], w_cur[c_mosi]};
    assign w_clr       = reset | ~w_cur[c_resn];

    assign w_col_end = (w_byte[6:0] > c_col_max) ? c_col_max : w_byte[6:0];
    assign w_row_end = (w_byte[5:0] > c_row_max) ? c_row_max : w_byte[5:0];

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'd0;
            r_state      <= c_st_idle;
            r_start_tmp  <= 7'd0;
            r_col_start  <= 7'd0;
            r_col_end    <= c_col_max;
            r_row_start  <= 6'd0;
            r_row_end    <= c_row_max;
            r_x          <= 7'd0;
            r_y          <= 6'd0;
            r_pix_valid  <= 1'b0;
            r_pix_x      <= 8'd0;
            r_pix_y      <= 6'd0;
            r_pix_color  <= 8'd0;
            r_cmd_valid  <= 1'b0;
            r_cmd_byte   <= 8'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_pix_valid  <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_frame_done <= 1'b0;

            if (w_shift) begin
                r_shift   <= w_byte;
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end else if (w_cur[c_csn]) begin
                r_shift   <= 8'd0;
                r_bit_cnt <= 3'd0;
            end

            if (w_byte_done) begin
                if (!w_cur[c_dc]) begin
                    r_cmd_valid <= 1'b1;
                    r_cmd_byte  <= w_byte;
                    case (r_state)
                        c_st_idle: begin
                            if (w_byte == 8'h15)      r_state <= c_st_col_s;
                            else if (w_byte == 8'h75) r_state <= c_st_row_s;
                        end
                        c_st_col_s: begin
                            r_start_tmp <= w_byte[6:0];
                            r_state     <= c_st_col_e;
                        end
                        c_st_col_e: begin
                            // An inverted window leaves the old one untouched
                            if (r_start_tmp <= w_col_end) begin
                                r_col_start <= r_start_tmp;
                                r_col_end   <= w_col_end;
                                r_x         <= r_start_tmp;
                            end
                            r_state <= c_st_idle;
                        end
                        c_st_row_s: begin
                            r_start_tmp <= {1'b0, w_byte[5:0]};
                            r_state     <= c_st_row_e;
                        end
                        c_st_row_e: begin
                            if (r_start_tmp[5:0] <= w_row_end) begin
                                r_row_start <= r_start_tmp[5:0];
                                r_row_end   <= w_row_end;
                                r_y         <= r_start_tmp[5:0];
                            end
                            r_state <= c_st_idle;
                        end
                        default: r_state <= c_st_idle;
                    endcase
                end else begin
                    // Pixel data aborts any half-received window command
                    r_state      <= c_st_idle;
                    r_pix_valid  <= 1'b1;
                    r_pix_x      <= {1'b0, r_x};
                    r_pix_y      <= r_y;
                    r_pix_color  <= w_byte;
                    r_frame_done <= (r_x == r_col_end) && (r_y == r_row_end);
                    if (r_x == r_col_end) begin
                        r_x <= r_col_start;
                        r_y <= (r_y == r_row_end) ? r_row_start : r_y + 6'd1;
                    end else begin
                        r_x <= r_x + 7'd1;
                    end
                end
            end
        end
    end

    assign bus.pix_valid  = r_pix_valid;
    assign bus.pix_x      = r_pix_x;
    assign bus.pix_y      = r_pix_y;
    assign bus.pix_color  = r_pix_color;
    assign bus.cmd_valid  = r_cmd_valid;
    assign bus.cmd_byte   = r_cmd_byte;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: doc/oled_spi_rx.md
Name: oled_spi_rx

Overview:
- SPI receiver/decoder for the SSD1331-style OLED stream that spi_video transmits (csn, clk, mosi, dc, resn).
- Oversamples the SPI pins in the system clock domain and frames bytes. It splits command bytes from pixel bytes, tracks the column/row address window, and emits one (x, y, color) write per pixel byte.
- Used as a display model in simulation and as a framebuffer-capture front end that feeds a pixel RAM write port.

Parameters:
- SCREEN_WIDTH, 96, columns; x wraps within window, window end clamped to SCREEN_WIDTH-1
- SCREEN_HEIGHT, 64, rows; window end clamped to SCREEN_HEIGHT-1
- SYNC_STAGES, 2, flip-flop synchronizer depth on every SPI input

Ports:
- clk  in  1  system clock; must be >= 4x oled_clk frequency
- reset  in  1  synchronous, active-high
- oled_csn  in  1  chip select, active low
- oled_clk  in  1  SPI clock, mode 0 (idle low, sample on rising edge)
- oled_mosi  in  1  serial data, MSB first
- oled_dc  in  1  0 = command/argument byte, 1 = pixel data byte
- oled_resn  in  1  display reset, active low
- pix_valid  out  1  one-cycle pulse per received pixel byte
- pix_x  out  8  column of the pixel, valid with pix_valid
- pix_y  out  6  row of the pixel, valid with pix_valid
- pix_color  out  8  RGB332 pixel value, valid with pix_valid
- cmd_valid  out  1  one-cycle pulse per received command-mode byte
- cmd_byte  out  8  command-mode byte, valid with cmd_valid
- frame_done  out  1  one-cycle pulse, coincident with pix_valid of the last pixel in the window

Behaviour:
Synchronizers:
- All five SPI inputs pass through SYNC_STAGES flops.
- Rising edge of oled_clk is detected from the last two synchronized samples.

Byte framing:
- 3-bit bit counter plus 8-bit shift register; mosi is shifted in at each detected rising edge while csn is low.
- oled_dc is sampled at the 8th rising edge.
- Latency: byte outputs pulse exactly SYNC_STAGES+1 clk cycles after the 8th oled_clk rise at the pins.
- csn high clears the bit counter and discards a partial byte; no output is produced.

Command decode (state machine on dc=0 bytes; every dc=0 byte also pulses cmd_valid):
- IDLE: byte 8'h15 -> COL_S; byte 8'h75 -> ROW_S; any other byte stays in IDLE.
- COL_S: byte[6:0] -> col_start; go to COL_E.
- COL_E: min(byte[6:0], SCREEN_WIDTH-1) -> col_end; x <= col_start; go to IDLE.
- ROW_S: byte[5:0] -> row_start; go to ROW_E.
- ROW_E: min(byte[5:0], SCREEN_HEIGHT-1) -> row_end; y <= row_start; go to IDLE.
- A start value greater than its end value: the whole window update is ignored and the previous window is retained.
- A dc=1 byte arriving in any non-IDLE state aborts to IDLE, keeps the old window, and is still processed as a pixel.

Pixel path (dc=1 byte):
- pix_valid=1, pix_x=x, pix_y=y, pix_color=byte.
- Address advance: if x==col_end then x <= col_start and y <= (y==row_end) ? row_start : y+1; else x <= x+1.
- frame_done=1 in the same cycle when x==col_end and y==row_end.

Reset:
- reset, or synchronized oled_resn=0, returns the block to its reset state:
  - window = (0, SCREEN_WIDTH-1, 0, SCREEN_HEIGHT-1); x=0, y=0
  - state IDLE, bit counter 0, shift register 0
  - all outputs 0
- Reset mid-byte drops the partial byte.

Simultaneous events:
- cmd_valid and pix_valid are never both high.
- csn rising in the same cycle as the 8th edge: the byte completes, then the bit counter clears.

Test Plan:
- Reset, then dc=1 stream of 96*64 bytes with color = index[7:0] -> 6144 pix_valid pulses. Pulse n has x=n%96, y=n/96, color=n[7:0]; frame_done only on n=6143.
- Commands 15 0A 0D 75 05 06 (dc=0), then 10 pixel bytes -> 6 cmd_valid pulses. Pixels land at (10..13,5), (10..13,6), then wrap to (10..11,5); frame_done on the 8th pixel.
- 5 bits shifted, csn high, csn low, 8 bits of 8'hA5 with dc=1 -> exactly one pix_valid with color A5 at (0,0).
- Command 15 followed by dc=1 byte 3C -> state aborts to IDLE, window unchanged, pix_valid color 3C at the current x,y.
- Column args 50 20 (start>end) -> window unchanged; next pixel at the pre-command position. Args 00 7F -> col_end clamped to 95.
- oled_resn pulsed low mid-frame at (40,30) -> next pixel at (0,0) with the full-screen window.
